// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code decoder: prefix parsing, modifiers, ASCII, event FIFO, press counter
// Optional typematic repeat filter enabled by defining KBD_REPEAT_FILTER_EN.
module ps2_key_decoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_ready,
  output logic                     rx_nextdata_n,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_break,
  output logic [7:0]               ev_ascii,
  output logic                     shift_st,
  output logic                     ctrl_st,
  output logic                     caps_st,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     overflow,
  output logic [CNT_W-1:0]         press_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DEC} state_t;

  state_t           r_state;
  logic [7:0]       r_byte;
  logic             r_nd_n;
  logic             r_ext_p;
  logic             r_brk_p;
  logic             r_lshift;
  logic             r_rshift;
  logic             r_ctrl;
  logic             r_caps;
  logic             r_ovf;
  logic [CNT_W-1:0] r_press;
  logic [17:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;

  logic       w_key, w_make, w_rep, w_emit;
  logic       w_is_lsh, w_is_rsh, w_is_ctrl, w_is_caps;
  logic       w_lsh_n, w_rsh_n, w_ctrl_n, w_caps_n, w_shift_n;
  logic       w_letter;
  logic [7:0] w_lower, w_sym, w_ascii;
  logic       w_full, w_pop, w_push;
  logic [17:0] w_head;

  assign w_key  = (r_state == S_DEC) && (r_byte != 8'hE0) && (r_byte != 8'hF0);
  assign w_make = w_key && !r_brk_p;
  assign w_emit = w_key && !w_rep;

  assign w_is_lsh  = !r_ext_p && (r_byte == 8'h12);
  assign w_is_rsh  = !r_ext_p && (r_byte == 8'h59);
  assign w_is_ctrl = (r_byte == 8'h14);
  assign w_is_caps = !r_ext_p && (r_byte == 8'h58);

  // Modifier state as it will be after this key, so the lookup sees it
  assign w_lsh_n   = (w_emit && w_is_lsh)  ? !r_brk_p : r_lshift;
  assign w_rsh_n   = (w_emit && w_is_rsh)  ? !r_brk_p : r_rshift;
  assign w_ctrl_n  = (w_emit && w_is_ctrl) ? !r_brk_p : r_ctrl;
  assign w_caps_n  = (w_emit && w_make && w_is_caps) ? !r_caps : r_caps;
  assign w_shift_n = w_lsh_n | w_rsh_n;

`ifdef KBD_REPEAT_FILTER_EN
  logic       r_held_v;
  logic       r_held_ext;
  logic [7:0] r_held_code;
  logic       w_held_match;

  assign w_held_match = r_held_v && (r_held_ext == r_ext_p) && (r_held_code == r_byte);
  assign w_rep        = w_make && w_held_match;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_held_v    <= 1'b0;
      r_held_ext  <= 1'b0;
      r_held_code <= 8'h00;
    end else if (w_key) begin
      if (!r_brk_p && !w_held_match) begin
        r_held_v    <= 1'b1;
        r_held_ext  <= r_ext_p;
        r_held_code <= r_byte;
      end else if (r_brk_p && w_held_match) begin
        r_held_v <= 1'b0;
      end
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  always_comb begin
    w_letter = 1'b1;
    w_lower  = 8'h00;
    w_sym    = 8'h00;
    case (r_byte)
      8'h1C: w_lower = 8'h61;  8'h32: w_lower = 8'h62;  8'h21: w_lower = 8'h63;
      8'h23: w_lower = 8'h64;  8'h24: w_lower = 8'h65;  8'h2B: w_lower = 8'h66;
      8'h34: w_lower = 8'h67;  8'h33: w_lower = 8'h68;  8'h43: w_lower = 8'h69;
      8'h3B: w_lower = 8'h6A;  8'h42: w_lower = 8'h6B;  8'h4B: w_lower = 8'h6C;
      8'h3A: w_lower = 8'h6D;  8'h31: w_lower = 8'h6E;  8'h44: w_lower = 8'h6F;
      8'h4D: w_lower = 8'h70;  8'h15: w_lower = 8'h71;  8'h2D: w_lower = 8'h72;
      8'h1B: w_lower = 8'h73;  8'h2C: w_lower = 8'h74;  8'h3C: w_lower = 8'h75;
      8'h2A: w_lower = 8'h76;  8'h1D: w_lower = 8'h77;  8'h22: w_lower = 8'h78;
      8'h35: w_lower = 8'h79;  8'h1A: w_lower = 8'h7A;
      default: begin
        w_letter = 1'b0;
        case (r_byte)
          8'h45: w_sym = 8'h30;  8'h16: w_sym = 8'h31;  8'h1E: w_sym = 8'h32;
          8'h26: w_sym = 8'h33;  8'h25: w_sym = 8'h34;  8'h2E: w_sym = 8'h35;
          8'h36: w_sym = 8'h36;  8'h3D: w_sym = 8'h37;  8'h3E: w_sym = 8'h38;
          8'h46: w_sym = 8'h39;  8'h29: w_sym = 8'h20;  8'h5A: w_sym = 8'h0D;
          8'h66: w_sym = 8'h08;
          default: w_sym = 8'h00;
        endcase
      end
    endcase

    w_ascii = 8'h00;
    if (!r_ext_p) begin
      if (!w_letter)
        w_ascii = w_sym;
      else if (w_ctrl_n)
        w_ascii = w_lower & 8'h1F;
      else if (w_shift_n ^ w_caps_n)
        w_ascii = w_lower - 8'h20;
      else
        w_ascii = w_lower;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= S_IDLE;
      r_byte   <= 8'h00;
      r_nd_n   <= 1'b1;
      r_ext_p  <= 1'b0;
      r_brk_p  <= 1'b0;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_ctrl   <= 1'b0;
      r_caps   <= 1'b0;
      r_press  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_byte  <= rx_data;
            r_nd_n  <= 1'b0;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_nd_n  <= 1'b1;
          r_state <= S_DEC;
        end
        S_DEC: begin
          r_state <= S_IDLE;
          if (r_byte == 8'hE0) begin
            r_ext_p <= 1'b1;
          end else if (r_byte == 8'hF0) begin
            r_brk_p <= 1'b1;
          end else begin
            r_ext_p  <= 1'b0;
            r_brk_p  <= 1'b0;
            r_lshift <= w_lsh_n;
            r_rshift <= w_rsh_n;
            r_ctrl   <= w_ctrl_n;
            r_caps   <= w_caps_n;
            if (w_emit && w_make)
              r_press <= r_press + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_full = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop  = (r_cnt != '0) && ev_ready;
  assign w_push = w_emit && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= {r_byte, r_ext_p, r_brk_p, w_ascii};
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - 1'b1;
      if (w_emit && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  assign w_head        = r_mem[r_rp];
  assign ev_valid      = (r_cnt != '0);
  assign ev_code       = ev_valid ? w_head[17:10] : 8'h00;
  assign ev_ext        = ev_valid & w_head[9];
  assign ev_break      = ev_valid & w_head[8];
  assign ev_ascii      = ev_valid ? w_head[7:0] : 8'h00;
  assign rx_nextdata_n = r_nd_n;
  assign shift_st      = r_lshift | r_rshift;
  assign ctrl_st       = r_ctrl;
  assign caps_st       = r_caps;
  assign fifo_cnt      = r_cnt;
  assign overflow      = r_ovf;
  assign press_cnt     = r_press;

endmodule
